// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: owns the PC, issues req/ack fetches and
// presents one registered instruction to decode. Optional FETCH_ALIGN_CHECK_EN flags misaligned redirects.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset_shl,
    input  logic        jalr_en,
    input  logic [31:0] jalr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready,
    output logic        misalign_err
);

    typedef enum logic [1:0] {BOOT, REQ, WAIT_SLOT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] inst_q, inst_d;
    logic        kill_q, kill_d;
    logic        redirect;
    logic [31:0] raw_tgt;
    logic [31:0] tgt;

    assign redirect = br_taken | jalr_en;
    assign raw_tgt  = br_taken ? (br_pc + br_offset_shl) : {jalr_target[31:1], 1'b0};

`ifdef FETCH_ALIGN_CHECK_EN
    logic mis_q;

    assign tgt          = {raw_tgt[31:2], 2'b00};
    assign misalign_err = mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= redirect & raw_tgt[1];
    end
`else
    assign tgt          = raw_tgt;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        ifpc_d  = ifpc_q;
        inst_d  = inst_q;
        kill_d  = kill_q;

        // Decode consuming the slot empties it unless a new word is loaded below.
        if (valid_q && if_ready) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end

        if (redirect) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            pc_d    = tgt;
            state_d = REQ;
            req_d   = 1'b1;
            // An unacked request must stay on the bus; its data is dropped via kill.
            if (state_q == REQ && !imem_ack) begin
                kill_d = 1'b1;
            end else begin
                kill_d = 1'b0;
                addr_d = tgt;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                            addr_d = pc_q;
                        end else begin
                            valid_d = 1'b1;
                            inst_d  = imem_rdata;
                            ifpc_d  = addr_q;
                            pc_d    = addr_q + 32'd4;
                            if (if_ready && !stall) begin
                                addr_d = addr_q + 32'd4;
                            end else begin
                                state_d = WAIT_SLOT;
                                req_d   = 1'b0;
                            end
                        end
                    end
                end
                WAIT_SLOT: begin
                    if ((!valid_q || if_ready) && !stall) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = BOOT;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            ifpc_q  <= 32'h0;
            inst_q  <= NOP_INST;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            ifpc_q  <= ifpc_d;
            inst_q  <= inst_d;
            kill_q  <= kill_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = ifpc_q;
    assign if_inst   = inst_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, backpressure, redirect/kill,
// priority, wrap with stall, alignment (FETCH_ALIGN_CHECK_EN aware) and reset mid-fetch.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic [31:0] br_offset_shl = 32'h0;
    logic        jalr_en = 1'b0;
    logic [31:0] jalr_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready = 1'b0;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_pc(br_pc), .br_offset_shl(br_offset_shl),
        .jalr_en(jalr_en), .jalr_target(jalr_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_ready(if_ready), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", if_pc); end
        checks++; if (if_inst !== NOP) begin errors++; $display("FAIL rst_inst got %h exp %h", if_inst, NOP); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", misalign_err); end
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL boot_addr got %h exp 0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", if_valid); end
    endtask

    task automatic test_sequential();
        if_ready = 1'b1;
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'hA000_0000 + i;
            step();
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got %b exp 1", i, if_valid); end
            checks++; if (if_pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, if_pc, 32'(i * 4)); end
            checks++; if (if_inst !== 32'hA000_0000 + i) begin errors++; $display("FAIL seq_inst%0d got %h exp %h", i, if_inst, 32'hA000_0000 + i); end
            checks++; if (imem_addr !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_addr%0d got %h exp %h", i, imem_addr, 32'(i * 4 + 4)); end
        end
    endtask

    task automatic test_backpressure();
        imem_ack = 1'b0;
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", if_valid); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL bp_hold_addr got %h exp 10", imem_addr); end
        if_ready = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h0050_0093;
        step();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_cap_valid got %b exp 1", if_valid); end
        checks++; if (if_pc !== 32'h10) begin errors++; $display("FAIL bp_cap_pc got %h exp 10", if_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_cap_req got %b exp 0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_inst !== 32'h0050_0093) begin errors++; $display("FAIL bp_inst%0d got %h exp 00500093", i, if_inst); end
            checks++; if (if_pc !== 32'h10) begin errors++; $display("FAIL bp_pc%0d got %h exp 10", i, if_pc); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req%0d got %b exp 0", i, imem_req); end
        end
        if_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL bp_resume_addr got %h exp 14", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL bp_resume_valid got %b exp 0", if_valid); end
    endtask

    task automatic test_redirect_kill();
        jalr_en = 1'b1;
        jalr_target = 32'h48;
        step();
        jalr_en = 1'b0;
        checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL kill_hold_addr got %h exp 14", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL kill_hold_req got %b exp 1", imem_req); end
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_0001;
        step();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL kill_drop_valid got %b exp 0", if_valid); end
        checks++; if (imem_addr !== 32'h48) begin errors++; $display("FAIL kill_issue_addr got %h exp 48", imem_addr); end
        br_taken = 1'b1;
        br_pc = 32'h40;
        br_offset_shl = 32'hFFFF_FFF0;
        step();
        br_taken = 1'b0;
        checks++; if (imem_addr !== 32'h48) begin errors++; $display("FAIL br_hold_addr got %h exp 48", imem_addr); end
        checks++; if (if_inst !== NOP) begin errors++; $display("FAIL br_flush_inst got %h exp %h", if_inst, NOP); end
        step();
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0048;
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_drop_valid got %b exp 0", if_valid); end
        checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL br_target_addr got %h exp 30", imem_addr); end
        imem_rdata = 32'h1111_0030;
        step();
        imem_ack = 1'b0;
        checks++; if (if_pc !== 32'h30 || if_valid !== 1'b1) begin errors++; $display("FAIL br_fetch got pc %h v %b exp 30 1", if_pc, if_valid); end
        checks++; if (if_inst !== 32'h1111_0030) begin errors++; $display("FAIL br_fetch_inst got %h exp 11110030", if_inst); end
    endtask

    task automatic test_priority();
        imem_ack = 1'b1;
        br_taken = 1'b1;
        br_pc = 32'hF0;
        br_offset_shl = 32'h10;
        jalr_en = 1'b1;
        jalr_target = 32'h201;
        step();
        br_taken = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL prio_addr got %h exp 100", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL prio_valid got %b exp 0", if_valid); end
        step();
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL jalr_addr got %h exp 200", imem_addr); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL jalr_mis got %b exp 0", misalign_err); end
    endtask

    task automatic test_wrap_stall();
        jalr_target = 32'hFFFF_FFFC;
        step();
        jalr_en = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
        imem_rdata = 32'hCAFE_0001;
        stall = 1'b1;
        if_ready = 1'b0;
        step();
        imem_ack = 1'b0;
        checks++; if (if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1) begin errors++; $display("FAIL wrap_cap got pc %h v %b exp fffffffc 1", if_pc, if_valid); end
        checks++; if (if_inst !== 32'hCAFE_0001) begin errors++; $display("FAIL wrap_inst got %h exp cafe0001", if_inst); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req0 got %b exp 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req1 got %b exp 0", imem_req); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", if_valid); end
        stall = 1'b0;
        if_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_align();
        logic [31:0] exp_addr;
        logic        exp_mis;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_addr = 32'h104;
        exp_mis  = 1'b1;
`else
        exp_addr = 32'h106;
        exp_mis  = 1'b0;
`endif
        imem_ack = 1'b1;
        jalr_en = 1'b1;
        jalr_target = 32'h106;
        step();
        jalr_en = 1'b0;
        imem_ack = 1'b0;
        checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL align_addr got %h exp %h", imem_addr, exp_addr); end
        checks++; if (misalign_err !== exp_mis) begin errors++; $display("FAIL align_mis got %b exp %b", misalign_err, exp_mis); end
        step();
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL align_mis_pulse got %b exp 0", misalign_err); end
        imem_ack = 1'b1;
        imem_rdata = 32'h2222_0106;
        step();
        imem_ack = 1'b0;
        checks++; if (if_pc !== exp_addr) begin errors++; $display("FAIL align_pc got %h exp %h", if_pc, exp_addr); end
    endtask

    task automatic test_reset_midfetch();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst got req %b addr %h exp 0 0", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0 || if_inst !== NOP) begin errors++; $display("FAIL mid_rst_slot got v %b inst %h exp 0 %h", if_valid, if_inst, NOP); end
        imem_ack = 1'b1;
        imem_rdata = 32'h3333_3333;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL late_ack_valid got %b exp 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL late_ack_req got req %b addr %h exp 1 0", imem_req, imem_addr); end
        imem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_kill();
        test_priority();
        test_wrap_stall();
        test_align();
        test_reset_midfetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
